// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle main control FSM: fetch/decode/execute/mem/writeback sequencing with memory-ready stalls.
// Define MC_PERF_CNT_EN to add the retired-instruction counter output instr_retired.
module mc_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 16
`ifdef MC_PERF_CNT_EN
  , parameter int CNT_W     = 32
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             iord,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             reg_we,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       En_UC,
  output logic             err,
  output logic [3:0]       state_dbg
`ifdef MC_PERF_CNT_EN
  , output logic [CNT_W-1:0] instr_retired
`endif
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_RD    = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WR    = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_ADDI_EXEC = 4'd9,
    S_ADDI_WB   = 4'd10,
    S_BRANCH    = 4'd11,
    S_JUMP      = 4'd12,
    S_ERROR     = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            r_state;
  state_t            w_nextState;
  logic [WAIT_W-1:0] r_waitCnt;
  logic              w_waitState;
  logic              w_timeout;

  assign w_waitState = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
  // A ready on the last allowed cycle still advances; only a missing ready times out.
  assign w_timeout   = w_waitState && !mem_ready && (r_waitCnt == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Counts stalled cycles while parked in a memory state; any state change restarts it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_waitCnt <= '0;
    end else if (w_waitState && !mem_ready && (w_nextState == r_state)) begin
      r_waitCnt <= r_waitCnt + WAIT_W'(1);
    end else begin
      r_waitCnt <= '0;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:   w_nextState = S_FETCH;
      S_FETCH: begin
        if (mem_ready) begin
          w_nextState = S_DECODE;
        end else if (w_timeout) begin
          w_nextState = S_ERROR;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:      w_nextState = S_R_EXEC;
          OP_LW, OP_SW:  w_nextState = S_MEM_ADDR;
          OP_BEQ:        w_nextState = S_BRANCH;
          OP_ADDI:       w_nextState = S_ADDI_EXEC;
          OP_J:          w_nextState = S_JUMP;
          default:       w_nextState = S_ERROR;
        endcase
      end
      S_MEM_ADDR: begin
        if (opcode == OP_LW) begin
          w_nextState = S_MEM_RD;
        end else if (opcode == OP_SW) begin
          w_nextState = S_MEM_WR;
        end else begin
          w_nextState = S_ERROR;
        end
      end
      S_MEM_RD: begin
        if (mem_ready) begin
          w_nextState = S_MEM_WB;
        end else if (w_timeout) begin
          w_nextState = S_ERROR;
        end
      end
      S_MEM_WB:    w_nextState = S_FETCH;
      S_MEM_WR: begin
        if (mem_ready) begin
          w_nextState = S_FETCH;
        end else if (w_timeout) begin
          w_nextState = S_ERROR;
        end
      end
      S_R_EXEC:    w_nextState = S_R_WB;
      S_R_WB:      w_nextState = S_FETCH;
      S_ADDI_EXEC: w_nextState = S_ADDI_WB;
      S_ADDI_WB:   w_nextState = S_FETCH;
      S_BRANCH:    w_nextState = S_FETCH;
      S_JUMP:      w_nextState = S_FETCH;
      S_ERROR:     w_nextState = S_ERROR;
      default:     w_nextState = S_ERROR;
    endcase
  end

  // Moore decode; only the FETCH write enables and the BRANCH pc_we look at inputs.
  always_comb begin
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    iord       = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 2'b00;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    En_UC      = 3'b000;
    err        = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_rd    = 1'b1;
        alu_src_b = 2'b01;
        En_UC     = 3'b001;
        ir_we     = mem_ready;
        pc_we     = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        En_UC     = 3'b001;
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        En_UC     = 3'b001;
      end
      S_MEM_RD: begin
        mem_rd = 1'b1;
        iord   = 1'b1;
      end
      S_MEM_WB: begin
        reg_we     = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_wr = 1'b1;
        iord   = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
      end
      S_R_WB: begin
        reg_we  = 1'b1;
        reg_dst = 1'b1;
      end
      S_ADDI_WB: begin
        reg_we = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        En_UC     = 3'b010;
        pc_src    = 2'b01;
        pc_we     = zero;
      end
      S_JUMP: begin
        pc_src = 2'b10;
        pc_we  = 1'b1;
      end
      S_ERROR: begin
        err = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign state_dbg = r_state;

`ifdef MC_PERF_CNT_EN
  logic             w_retire;
  logic [CNT_W-1:0] r_retired;

  // An instruction retires when its final state hands control back to FETCH.
  assign w_retire = (w_nextState == S_FETCH) &&
                    (r_state inside {S_MEM_WB, S_MEM_WR, S_R_WB, S_ADDI_WB, S_BRANCH, S_JUMP});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_retired <= '0;
    end else if (w_retire) begin
      r_retired <= r_retired + CNT_W'(1);
    end
  end

  assign instr_retired = r_retired;
`endif

endmodule
